// File: rtl/minmax_pkg.sv
// Shared types for the min/max window controller.
// Holds the FSM state encoding, the default counter width and the
// datapath strobe bundle driven by the controller.
package minmax_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Strobes towards the sample/min/max register datapath
  typedef struct packed {
    logic reg_clr;
    logic min_clr;
    logic max_clr;
    logic reg_ld;
    logic min_ld;
    logic max_ld;
  } strobe_t;

endpackage

// File: rtl/minmax_window_ctrl_win_counter.sv
// Window counter for the min/max controller.
// Tracks samples accepted in the current window, latches the window length
// and flags when the next accepted sample is the last one.
// Optional MINMAX_STALL_CNT_EN: adds a saturating count of stalled RUN cycles.
// Ports:
//   clk, rst       clock, async active-low reset
//   clr_i          clear count (and stall count)
//   inc_i          one sample accepted
//   len_ld_i       latch win_len_i as the window length
//   win_len_i      requested window length
//   stall_i        RUN cycle without a sample (feature build only)
//   stall_cnt_o    saturating stall count (feature build only)
//   count_o        samples accepted so far
//   last_o         count_o == length-1
module minmax_window_ctrl_win_counter
  import minmax_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             len_ld_i,
  input  logic [CNT_W-1:0] win_len_i,
`ifdef MINMAX_STALL_CNT_EN
  input  logic             stall_i,
  output logic [CNT_W-1:0] stall_cnt_o,
`endif
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;

  // Next count / length
  always_comb begin
    count_d = count_q;
    len_d   = len_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
    if (len_ld_i) begin
      len_d = win_len_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      len_q   <= '0;
    end else begin
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // Length is never zero while counting, so len-1 cannot underflow in use
  assign last_o  = (count_q == (len_q - CNT_W'(1)));
  assign count_o = count_q;

`ifdef MINMAX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating stall counter
  always_comb begin
    stall_d = stall_q;
    if (clr_i) begin
      stall_d = '0;
    end else if (stall_i && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: rtl/minmax_window_ctrl.sv
// Sequencer for the sample/min/max tracking datapath.
// Clears the datapath, accepts win_len samples over valid/ready, drives the
// min/max load strobes from the datapath comparators one cycle after each
// sample load, and holds done once the window is final.
// Optional MINMAX_STALL_CNT_EN: adds stall_cnt output.
// Ports:
//   clk, rst                   clock, async active-low reset
//   start, abort               begin window / return to IDLE
//   win_len                    samples per window, latched on accepted start
//   in_valid, in_ready         sample handshake
//   lt_min, gt_max             datapath comparator results
//   reg_clr, min_clr, max_clr  datapath clears
//   reg_ld, min_ld, max_ld     datapath loads (combinational from inputs)
//   done, err                  window complete / zero-length start pulse
//   count                      samples accepted in the current window
//   stall_cnt                  stalled RUN cycles (feature build only)
module minmax_window_ctrl
  import minmax_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             lt_min,
  input  logic             gt_max,
  output logic             reg_clr,
  output logic             min_clr,
  output logic             max_clr,
  output logic             reg_ld,
  output logic             min_ld,
  output logic             max_ld,
  output logic             done,
  output logic             err,
`ifdef MINMAX_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [CNT_W-1:0] count
);

  state_e  state_q, state_d;
  logic    pend_q, pend_d;
  logic    first_q, first_d;
  logic    err_q, err_d;
  logic    len_ld;
  logic    hs;
  logic    last;
  strobe_t stb;

  assign in_ready = (state_q == RUN);
  assign hs       = in_valid & in_ready;

  // Next state, compare-pending and first-sample tracking
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    first_d = first_q & ~pend_q;   // first sample's compare retires the flag
    err_d   = 1'b0;
    len_ld  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (win_len != '0) begin
            state_d = CLR;
            len_ld  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLR: begin
        first_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        pend_d = hs;
        if (hs && last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      first_d = 1'b0;
      err_d   = 1'b0;
      len_ld  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Datapath strobes: clears from state, loads from handshake / comparators
  always_comb begin
    stb         = '0;
    stb.reg_clr = (state_q == CLR);
    stb.min_clr = (state_q == CLR);
    stb.max_clr = (state_q == CLR);
    stb.reg_ld  = hs;
    stb.min_ld  = pend_q & (first_q | lt_min);
    stb.max_ld  = pend_q & (first_q | gt_max);
  end

  assign reg_clr = stb.reg_clr;
  assign min_clr = stb.min_clr;
  assign max_clr = stb.max_clr;
  assign reg_ld  = stb.reg_ld;
  assign min_ld  = stb.min_ld;
  assign max_ld  = stb.max_ld;
  assign done    = (state_q == DONE);
  assign err     = err_q;

  // Count is cleared on the accepting start so CLR already shows zero
  minmax_window_ctrl_win_counter #(
    .CNT_W (CNT_W)
  ) u_win_counter (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (len_ld | (state_q == CLR)),
    .inc_i       (hs & ~abort),
    .len_ld_i    (len_ld),
    .win_len_i   (win_len),
`ifdef MINMAX_STALL_CNT_EN
    .stall_i     ((state_q == RUN) & ~in_valid),
    .stall_cnt_o (stall_cnt),
`endif
    .count_o     (count),
    .last_o      (last)
  );

endmodule

// File: tb/tb_minmax_window_ctrl.sv
// Directed, table-driven bench for minmax_window_ctrl.
module tb_minmax_window_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] win_len;
  logic       in_valid;
  logic       in_ready;
  logic       lt_min;
  logic       gt_max;
  logic       reg_clr, min_clr, max_clr;
  logic       reg_ld, min_ld, max_ld;
  logic       done;
  logic       err;
  logic [7:0] count;
`ifdef MINMAX_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  int n_vec;
  int n_bad;

  minmax_window_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .win_len   (win_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lt_min    (lt_min),
    .gt_max    (gt_max),
    .reg_clr   (reg_clr),
    .min_clr   (min_clr),
    .max_clr   (max_clr),
    .reg_ld    (reg_ld),
    .min_ld    (min_ld),
    .max_ld    (max_ld),
    .done      (done),
    .err       (err),
`ifdef MINMAX_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed bundle: in_ready, 3 clears, 3 loads, done, err, count
  logic [16:0] obs;
  assign obs = {in_ready, reg_clr, min_clr, max_clr, reg_ld, min_ld, max_ld,
                done, err, count};

  // Flags order: in_ready, clr(all three), reg_ld, min_ld, max_ld, done, err
  typedef struct {
    logic       s;
    logic       a;
    logic [7:0] wl;
    logic       v;
    logic       lt;
    logic       gt;
    logic [6:0] f;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [16:0] expand(input logic [6:0] f, input logic [7:0] c);
    return {f[6], {3{f[5]}}, f[4:0], c};
  endfunction

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic a, input logic [7:0] wl,
                     input logic v, input logic lt, input logic gt,
                     input logic [6:0] f, input logic [7:0] c);
    vec_t e;
    e.s = s; e.a = a; e.wl = wl; e.v = v; e.lt = lt; e.gt = gt; e.f = f; e.c = c;
    tbl.push_back(e);
  endtask

  // One cycle: drive after the falling edge, compare mid low phase
  task automatic step(input string nm, input logic s, input logic a,
                      input logic [7:0] wl, input logic v, input logic lt,
                      input logic gt, input logic [6:0] f, input logic [7:0] c);
    @(negedge clk);
    start = s; abort = a; win_len = wl; in_valid = v; lt_min = lt; gt_max = gt;
    #2;
    check(nm, obs, expand(f, c));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    start = 1'b0; abort = 1'b0; win_len = 8'd0;
    in_valid = 1'b1; lt_min = 1'b1; gt_max = 1'b1;
    #12;
    check("reset", obs, expand(7'b0000000, 8'd0));

    //   s     a     wl     v     lt    gt    flags        count
    // Basic window: len 4, samples 5,3,9,7
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd0);
    add(1'b1, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd0);  // t
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0100000, 8'd0);  // CLR
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 7'b1010000, 8'd0);  // load 5
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 7'b1011100, 8'd1);  // load 3, cmp 5 first
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 7'b1011000, 8'd2);  // load 9, cmp 3
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 7'b1010100, 8'd3);  // load 7, cmp 9
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd4);  // DRAIN, cmp 7
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd4);  // DONE
    // Back-to-back: len 2, samples 2,6
    add(1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd4);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0100000, 8'd0);  // CLR
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 7'b1010000, 8'd0);  // load 2
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 7'b1011100, 8'd1);  // load 6, cmp 2 first
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 7'b0000100, 8'd2);  // DRAIN, cmp 6
    // Zero length in DONE, then abort from DONE, then zero length in IDLE
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd2);
    add(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0000011, 8'd2);  // err, abort
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd2);  // IDLE
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0000001, 8'd2);  // err, no clr
    // Stalls: len 3, samples 4,8,1 with two idle cycles between
    add(1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd2);
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0100000, 8'd0);  // CLR
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 7'b1010000, 8'd0);  // load 4
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 7'b1001100, 8'd1);  // stall, cmp 4 first
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'd1);  // stall
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 7'b1010000, 8'd1);  // load 8
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 7'b1000100, 8'd2);  // stall, cmp 8
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b1000000, 8'd2);  // stall
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 7'b1010000, 8'd2);  // load 1
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 7'b0001000, 8'd3);  // DRAIN, cmp 1
    add(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd3);  // DONE at t+10

    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].wl, tbl[i].v,
           tbl[i].lt, tbl[i].gt, tbl[i].f, tbl[i].c);
    end
`ifdef MINMAX_STALL_CNT_EN
    check("stall_cnt", {9'd0, stall_cnt}, {9'd0, 8'd4});
`endif

    // Abort mid-run: len 8, abort with the 4th sample in flight
    step("ab_start", 1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 1'b0, 7'b0000010, 8'd3);
    step("ab_clr",   1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0100000, 8'd0);
    step("ab_s1",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 7'b1010000, 8'd0);
    step("ab_s2",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 7'b1011100, 8'd1);
    step("ab_s3",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 7'b1010000, 8'd2);
    step("ab_cycle", 1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 7'b1011000, 8'd3);
    step("ab_idle",  1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 7'b0000000, 8'd3);
    step("ab_idle2", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 7'b0000000, 8'd3);

    // Asynchronous reset in the middle of a RUN cycle
    step("rs_start", 1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 7'b0000000, 8'd3);
    step("rs_clr",   1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 7'b0100000, 8'd0);
    step("rs_s1",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 7'b1010000, 8'd0);
    step("rs_s2",    1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 7'b1011100, 8'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rs_async", obs, expand(7'b0000000, 8'd0));
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; lt_min = 1'b0; gt_max = 1'b0;
    #2;
    check("rs_release", obs, expand(7'b0000000, 8'd0));
    step("rs_idle", 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 7'b0000000, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
